sevenseg_scan_driver: RTL and testbench
=======================================

# sevenseg_scan_driver

Parametrised, time-multiplexed multi-digit seven-segment display driver. Accepts a packed BCD word for DIGITS digits plus per-digit decimal points, double-buffers it so updates never tear mid-frame, and scans the digits one at a time onto a shared active-low segment bus with active-low digit enables. Sits between the arithmetic and counter blocks and the board display pins. It is the multi-digit, registered successor of the single-digit BCD decoder.

## Interface
- DIGITS, 4, number of display digits (≥2).
- DIV, 1000, clock cycles each digit stays lit (≥2).
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  one-cycle strobe; captures bcd_in/dp_in.
- bcd_in  input  4*DIGITS  digit i = bcd_in[4i+3:4i], digit 0 least significant.
- dp_in  input  DIGITS  decimal point request, bit i for digit i (1 = lit).
- blank_lz  input  1  1 = suppress leading zeros.
- seg  output  7  active-low segments, seg[6:0] = a,b,c,d,e,f,g.
- dp_n  output  1  active-low decimal point of current digit.
- an  output  DIGITS  active-low digit enables, exactly one low when running.
- pending  output  1  shadow holds data not yet displayed.
- frame_done  output  1  one-cycle pulse when the scan wraps to digit 0.

## Operation
- Registers: prescaler cnt (0..DIV-1), digit index idx (0..DIGITS-1), shadow word/dp, active word/dp, pending flag.
- tick = (cnt == DIV-1); cnt wraps to 0 on tick, else increments.
- On tick: idx increments; DIGITS-1 wraps to 0 (wrap event).
- load: shadow <= {bcd_in, dp_in}, pending <= 1. Load while pending: overwrite, last wins.
- Wrap event with pending: active <= shadow, pending <= 0.
- Wrap event in the same cycle as load: active <= bcd_in/dp_in directly, shadow also updated, pending stays 0.
- Load with no later wrap: data remains pending; displayed content unchanged.
- Decode (active-low abcdefg): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100. Codes 10–15 are defined under Configuration.
- Leading-zero blank: digit i (i≠0) shows 1111111 when blank_lz=1 and every active digit i..DIGITS-1 equals 0. Digit 0 is never LZ-blanked. Non-decimal codes count as nonzero.
- dp_n = ~active_dp[idx], independent of blanking.
- an = all ones except bit idx low.

## Timing
- Reset values: cnt=0, idx=0, shadow=0, active=0, pending=0, seg=1111111, dp_n=1, an=all ones, frame_done=0.
- seg, dp_n and an are registered and reflect idx one cycle later. The first cycle after reset release shows digit 0 (an[0]=0).
- Each digit is lit for exactly DIV cycles; frame period is DIGITS*DIV cycles.
- frame_done is high in the cycle after the wrap tick, i.e. aligned with the first registered output of the new frame and of the new active data.
- Load-to-display latency is at most DIGITS*DIV+1 cycles. pending falls together with frame_done.
- blank_lz is combinational into the registered decode, so a change takes effect on the next output register update (one cycle).
- Reset asserted mid-frame returns every register to its reset value immediately and discards pending data.

## Configuration
- SEVSEG_HEX_EN defined: codes 10–15 display A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- Not defined: codes 10–15 display blank (1111111), legacy behaviour. They still count as nonzero for leading-zero blanking.

## Test plan
All scenarios use DIGITS=4, DIV=4.
- Reset, then release -> seg=1111111/an=1111 during reset; next cycle an=1110, seg=0000001; an steps 1101, 1011, 0111 every 4 cycles; frame_done pulses every 16 cycles.
- load bcd_in=16'h1234, dp_in=4'b0010 mid-frame -> pending=1; display is unchanged until the wrap; then digit0 seg=1001100, digit1 seg=0000110 with dp_n=0, digit2 2, digit3 1; pending clears with frame_done.
- load 16'h0070, blank_lz=1 -> digits 3 and 2 blank, digit1=0001111, digit0=0000001. With blank_lz=0, digits 3 and 2 show 0000001.
- load 16'h0000 with blank_lz=1 -> only digit0 shows 0000001.
- Two loads (16'h1111 then 16'h2222) before a wrap -> only 2222 is ever displayed. A load coinciding with the wrap tick -> the new value is displayed in that frame and pending=0.
- load 16'h00AF -> with SEVSEG_HEX_EN, digit0=0111000 and digit1=0001000; without it, both are 1111111 and digits 2–3 are LZ-blanked when blank_lz=1.

Source files
------------

// File: rtl/sevenseg_scan_driver_if.sv
// Bundle between a BCD data source and the multiplexed seven-segment driver.
interface sevenseg_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   bcd_in;
    logic [DIGITS-1:0]     dp_in;
    logic                  blank_lz;
    logic [6:0]            seg;
    logic                  dp_n;
    logic [DIGITS-1:0]     an;
    logic                  pending;
    logic                  frame_done;

    modport master (
        output load, bcd_in, dp_in, blank_lz,
        input  seg, dp_n, an, pending, frame_done
    );

    modport slave (
        input  load, bcd_in, dp_in, blank_lz,
        output seg, dp_n, an, pending, frame_done
    );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// Double-buffered, time-multiplexed seven-segment scan driver (active-low pins).
// Define SEVSEG_HEX_EN to display codes 10-15 as A,b,C,d,E,F instead of blank.
module sevenseg_scan_driver #(
    parameter int DIGITS = 4,
    parameter int DIV    = 1000
) (
    input logic                   clk,
    input logic                   rst,
    sevenseg_scan_driver_if.slave bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam logic [6:0] BLANK = 7'b1111111;

    logic [CW-1:0]         cnt, cnt_nxt;
    logic [IW-1:0]         idx, idx_nxt;
    logic [4*DIGITS-1:0]   shadow_bcd, active_bcd, act_bcd_nxt;
    logic [DIGITS-1:0]     shadow_dp, active_dp, act_dp_nxt;
    logic                  pending, pending_nxt;
    logic                  tick, wrap;
    logic [DIGITS-1:0]     lz;
    logic [3:0]            cur;
    logic [6:0]            seg_nxt, seg_q;
    logic                  dp_n_q;
    logic [DIGITS-1:0]     an_q;
    logic                  frame_done_q;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        s = BLANK;
        unique case (v)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
`ifdef SEVSEG_HEX_EN
            4'd10:   s = 7'b0001000;
            4'd11:   s = 7'b1100000;
            4'd12:   s = 7'b0110001;
            4'd13:   s = 7'b1000010;
            4'd14:   s = 7'b0110000;
            4'd15:   s = 7'b0111000;
`endif
            default: s = BLANK;
        endcase
        return s;
    endfunction

    assign tick = (cnt == CW'(DIV - 1));
    assign wrap = tick && (idx == IW'(DIGITS - 1));

    // A load landing on the wrap bypasses the shadow so it shows this frame.
    always_comb begin
        cnt_nxt     = tick ? '0 : cnt + 1'b1;
        idx_nxt     = idx;
        act_bcd_nxt = active_bcd;
        act_dp_nxt  = active_dp;
        pending_nxt = pending;
        if (tick)
            idx_nxt = wrap ? '0 : idx + 1'b1;
        if (wrap) begin
            pending_nxt = 1'b0;
            if (bus.load) begin
                act_bcd_nxt = bus.bcd_in;
                act_dp_nxt  = bus.dp_in;
            end else if (pending) begin
                act_bcd_nxt = shadow_bcd;
                act_dp_nxt  = shadow_dp;
            end
        end else if (bus.load) begin
            pending_nxt = 1'b1;
        end
    end

    // lz[i] set when digit i and every digit above it is zero.
    always_comb begin
        logic run;
        run = 1'b1;
        lz  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run   = run && (act_bcd_nxt[4*i +: 4] == 4'd0);
            lz[i] = run;
        end
    end

    // Output registers decode the next-state digit so new data and frame_done line up.
    always_comb begin
        cur     = act_bcd_nxt[{idx_nxt, 2'b00} +: 4];
        seg_nxt = decode(cur);
        if (bus.blank_lz && (idx_nxt != '0) && lz[idx_nxt])
            seg_nxt = BLANK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            idx          <= '0;
            shadow_bcd   <= '0;
            shadow_dp    <= '0;
            active_bcd   <= '0;
            active_dp    <= '0;
            pending      <= 1'b0;
            seg_q        <= BLANK;
            dp_n_q       <= 1'b1;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            idx          <= idx_nxt;
            active_bcd   <= act_bcd_nxt;
            active_dp    <= act_dp_nxt;
            pending      <= pending_nxt;
            if (bus.load) begin
                shadow_bcd <= bus.bcd_in;
                shadow_dp  <= bus.dp_in;
            end
            seg_q        <= seg_nxt;
            dp_n_q       <= ~act_dp_nxt[idx_nxt];
            an_q         <= ~(DIGITS'(1) << idx_nxt);
            frame_done_q <= wrap;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.an         = an_q;
    assign bus.pending    = pending;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver with DIGITS=4, DIV=4.
module tb_sevenseg_scan_driver;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S5 = 7'b0100100;
    localparam logic [6:0] S6 = 7'b0100000;
    localparam logic [6:0] S7 = 7'b0001111;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0000100;

    typedef struct {
        logic [15:0]      bcd;
        logic [3:0]       dp;
        logic             blz;
        logic [3:0][6:0]  segs;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n = 0;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl [8];
    vec_t v;

    sevenseg_scan_driver_if #(.DIGITS(4)) bus ();

    sevenseg_scan_driver #(.DIGITS(4), .DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, n);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        n++;
    endtask

    task automatic chk_digit(input int d, input logic [6:0] s,
                             input logic dpn);
        logic [3:0] an_exp;
        an_exp = ~(4'b0001 << d);
        chk($sformatf("an d%0d", d), 32'(bus.an), 32'(an_exp));
        chk($sformatf("seg d%0d", d), 32'(bus.seg), 32'(s));
        chk($sformatf("dp_n d%0d", d), 32'(bus.dp_n), 32'(dpn));
    endtask

    task automatic do_load(input logic [15:0] b, input logic [3:0] p,
                           input logic z);
        bus.load     = 1'b1;
        bus.bcd_in   = b;
        bus.dp_in    = p;
        bus.blank_lz = z;
        step();
        bus.load = 1'b0;
        chk("pending after load", 32'(bus.pending), 32'd1);
    endtask

    task automatic wait_fd();
        int k;
        k = 0;
        step();
        while (!bus.frame_done && k < 40) begin
            step();
            k++;
        end
        if (!bus.frame_done) begin
            errors++;
            $display("FAIL frame_done timeout: got 0 expected 1");
        end
    endtask

    task automatic run_frame(input vec_t t);
        wait_fd();
        chk("pending at frame_done", 32'(bus.pending), 32'd0);
        for (int d = 0; d < 4; d++) begin
            if (d > 0) repeat (4) step();
            chk_digit(d, t.segs[d], ~t.dp[d]);
        end
    endtask

    initial begin
        bus.load     = 1'b0;
        bus.bcd_in   = '0;
        bus.dp_in    = '0;
        bus.blank_lz = 1'b0;

        tbl[0] = '{16'h1234, 4'b0010, 1'b0, {S1, S2, S3, S4}};
        tbl[1] = '{16'h0070, 4'b0000, 1'b1, {BL, BL, S7, S0}};
        tbl[2] = '{16'h0070, 4'b0000, 1'b0, {S0, S0, S7, S0}};
        tbl[3] = '{16'h0000, 4'b0000, 1'b1, {BL, BL, BL, S0}};
`ifdef SEVSEG_HEX_EN
        tbl[4] = '{16'h00AF, 4'b0000, 1'b1, {BL, BL, 7'b0001000, 7'b0111000}};
        tbl[5] = '{16'h00AF, 4'b0000, 1'b0, {S0, S0, 7'b0001000, 7'b0111000}};
`else
        tbl[4] = '{16'h00AF, 4'b0000, 1'b1, {BL, BL, BL, BL}};
        tbl[5] = '{16'h00AF, 4'b0000, 1'b0, {S0, S0, BL, BL}};
`endif
        tbl[6] = '{16'h9876, 4'b1111, 1'b1, {S9, S8, S7, S6}};
        tbl[7] = '{16'h0509, 4'b0100, 1'b1, {BL, S5, S0, S9}};

        // Reset values, then the free-running scan.
        repeat (2) @(negedge clk);
        chk("rst seg", 32'(bus.seg), 32'(BL));
        chk("rst an", 32'(bus.an), 32'hF);
        chk("rst dp_n", 32'(bus.dp_n), 32'd1);
        chk("rst pending", 32'(bus.pending), 32'd0);
        chk("rst frame_done", 32'(bus.frame_done), 32'd0);
        rst = 1'b0;
        n = 0;
        step();
        chk_digit(0, S0, 1'b1);
        while (n < 32) begin
            step();
            if (n == 4) chk("an step1", 32'(bus.an), 32'hD);
            if (n == 8) chk("an step2", 32'(bus.an), 32'hB);
            if (n == 12) chk("an step3", 32'(bus.an), 32'h7);
            if (n == 15) chk("fd low", 32'(bus.frame_done), 32'd0);
            if (n == 16) chk("fd frame1", 32'(bus.frame_done), 32'd1);
            if (n == 17) chk("fd pulse", 32'(bus.frame_done), 32'd0);
            if (n == 32) chk("fd frame2", 32'(bus.frame_done), 32'd1);
        end

        for (int i = 0; i < 8; i++) begin
            do_load(tbl[i].bcd, tbl[i].dp, tbl[i].blz);
            run_frame(tbl[i]);
        end

        // Two loads before a wrap: last one wins.
        do_load(16'h1111, 4'b0000, 1'b0);
        do_load(16'h2222, 4'b0000, 1'b0);
        v = '{16'h2222, 4'b0000, 1'b0, {S2, S2, S2, S2}};
        run_frame(v);

        // Load coinciding with the wrap tick.
        while (n % 16 != 15) step();
        bus.load   = 1'b1;
        bus.bcd_in = 16'h4321;
        bus.dp_in  = 4'b0000;
        step();
        bus.load = 1'b0;
        chk("wrap-load fd", 32'(bus.frame_done), 32'd1);
        chk("wrap-load pending", 32'(bus.pending), 32'd0);
        chk_digit(0, S1, 1'b1);
        repeat (4) step();
        chk_digit(1, S2, 1'b1);

        // Pending data does not disturb the current frame.
        do_load(16'h8888, 4'b0000, 1'b0);
        repeat (4) step();
        chk_digit(2, S3, 1'b1);
        chk("still pending", 32'(bus.pending), 32'd1);
        v = '{16'h8888, 4'b0000, 1'b0, {S8, S8, S8, S8}};
        run_frame(v);

        // Mid-frame reset discards pending data.
        do_load(16'h0005, 4'b0000, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid rst pending", 32'(bus.pending), 32'd0);
        chk("mid rst an", 32'(bus.an), 32'hF);
        chk("mid rst seg", 32'(bus.seg), 32'(BL));
        chk("mid rst dp_n", 32'(bus.dp_n), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        step();
        chk_digit(0, S0, 1'b1);

        // blank_lz takes effect on the next output update.
        bus.blank_lz = 1'b1;
        while (n < 4) step();
        chk_digit(1, BL, 1'b1);
        bus.blank_lz = 1'b0;
        step();
        chk_digit(1, S0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
